rgb_frame_streamer: RTL and testbench

- Downstream neighbour of the upsampling/colour-space-conversion stage.
- Reads the packed RGB frame that stage writes into external SRAM, one 320x240 frame per start pulse.
- Unpacks three 16-bit words into two 24-bit pixels and streams them in raster order over a valid/ready interface to the VGA output path.
- A small pixel FIFO with credit-based read issue absorbs backpressure, so no SRAM read is ever lost.

---
 rtl/rgb_frame_streamer_if.sv | 30 +++
 rtl/rgb_frame_streamer.sv | 232 +++++++++++++++++++++++
 tb/tb_rgb_frame_streamer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_frame_streamer_if.sv
// -----------------------------------------------------------------------------
// rgb_frame_streamer_if
//   Pixel stream bundle between rgb_frame_streamer and the VGA output path.
//   Valid/ready handshake plus the head pixel colour and raster coordinates.
//
//   pixel_valid  streamer -> consumer   head entry holds a pixel
//   pixel_ready  consumer -> streamer   head pixel accepted this cycle
//   pixel_R/G/B  streamer -> consumer   head pixel colour, 8 bits each
//   pixel_x      streamer -> consumer   column of head pixel
//   pixel_y      streamer -> consumer   row of head pixel
// -----------------------------------------------------------------------------
interface rgb_frame_streamer_if;
   logic       pixel_valid;
   logic       pixel_ready;
   logic [7:0] pixel_R;
   logic [7:0] pixel_G;
   logic [7:0] pixel_B;
   logic [8:0] pixel_x;
   logic [7:0] pixel_y;

   modport master (
      output pixel_valid, pixel_R, pixel_G, pixel_B, pixel_x, pixel_y,
      input  pixel_ready
   );

   modport slave (
      input  pixel_valid, pixel_R, pixel_G, pixel_B, pixel_x, pixel_y,
      output pixel_ready
   );
endinterface

// File: rtl/rgb_frame_streamer.sv
// -----------------------------------------------------------------------------
// rgb_frame_streamer
//   Reads one packed RGB frame from external SRAM per start pulse, unpacks
//   every three 16-bit words into two 24-bit pixels and streams them in raster
//   order over a valid/ready interface. A small pixel FIFO with credit-based
//   read issue absorbs backpressure so no returning SRAM word is ever dropped.
//
//   Memory layout (upper byte first):
//     word 3k   = {R(2k),   G(2k)}
//     word 3k+1 = {B(2k),   R(2k+1)}
//     word 3k+2 = {G(2k+1), B(2k+1)}
//
//   Ports:
//     CLOCK_50_I      in   system clock
//     Resetn          in   asynchronous active-low reset
//     start_bit       in   one-cycle frame request, honoured only when idle
//     SRAM_read_data  in   SRAM read data (16 bits)
//     address         out  registered SRAM word address (18 bits)
//     write_en_n      out  SRAM write enable, active low, held high
//     busy            out  high from accepted start until frame_done
//     frame_done      out  one-cycle pulse after the last pixel is popped
//     pix             master side of the pixel stream interface
// -----------------------------------------------------------------------------
module rgb_frame_streamer #(
   parameter logic [17:0] RGB_BASE   = 18'd146944,
   parameter int unsigned IMG_W      = 320,
   parameter int unsigned IMG_H      = 240,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned SRAM_LAT   = 3
) (
   input  logic                 CLOCK_50_I,
   input  logic                 Resetn,
   input  logic                 start_bit,
   input  logic [15:0]          SRAM_read_data,
   output logic [17:0]          address,
   output logic                 write_en_n,
   output logic                 busy,
   output logic                 frame_done,
   rgb_frame_streamer_if.master pix
);

   localparam int unsigned NUM_WORDS = IMG_W * IMG_H * 3 / 2;
   localparam logic [17:0] LAST_ADDR = 18'(32'(RGB_BASE) + NUM_WORDS - 32'd1);
   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = AW + 1;
   localparam int unsigned SW        = CW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state;
   logic [17:0] rd_addr;
   logic [1:0]  iss_phase;

   // read-return tag pipeline
   logic [SRAM_LAT-1:0] pipe_vld;
   logic [1:0]          pipe_ph [SRAM_LAT];
   logic                ret_vld;
   logic [1:0]          ret_ph;
   logic                in_flight;

   // unpack holding registers
   logic [7:0] r0_q, g0_q, r1_q;

   // pixel FIFO
   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_idx, rd_idx;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] resv_cnt, resv_next;
   logic          push, pop;
   logic [23:0]   push_data;

   logic [8:0] x_cnt;
   logic [7:0] y_cnt;

   logic credit_ok, grp_start, issue;

   assign write_en_n = 1'b1;

   // A group only starts when the two pixels it will produce are guaranteed
   // a slot, counting pixels already in flight as reserved.
   assign credit_ok = (SW'(fifo_cnt) + SW'(resv_cnt)) <= SW'(FIFO_DEPTH - 2);
   assign grp_start = (state == S_ISSUE) && (iss_phase == 2'd0) && credit_ok;
   assign issue     = (state == S_ISSUE) && ((iss_phase != 2'd0) || credit_ok);

   assign ret_vld   = pipe_vld[SRAM_LAT-1];
   assign ret_ph    = pipe_ph[SRAM_LAT-1];
   assign in_flight = |pipe_vld;

   assign push      = ret_vld && (ret_ph != 2'd0);
   assign push_data = (ret_ph == 2'd1) ? {r0_q, g0_q, SRAM_read_data[15:8]}
                                       : {r1_q, SRAM_read_data};

   assign pix.pixel_valid = (fifo_cnt != '0);
   assign pop             = pix.pixel_valid && pix.pixel_ready;
   assign pix.pixel_R     = fifo_mem[rd_idx][23:16];
   assign pix.pixel_G     = fifo_mem[rd_idx][15:8];
   assign pix.pixel_B     = fifo_mem[rd_idx][7:0];
   assign pix.pixel_x     = x_cnt;
   assign pix.pixel_y     = y_cnt;

   always_comb begin
      resv_next = resv_cnt;
      if (grp_start) resv_next = resv_next + CW'(2);
      if (push)      resv_next = resv_next - CW'(1);
   end

   // -------------------------------------------------------------------------
   // Control FSM and read issue
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         state      <= S_IDLE;
         rd_addr    <= '0;
         iss_phase  <= '0;
         address    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               frame_done <= 1'b0;
               if (start_bit) begin
                  state     <= S_ISSUE;
                  busy      <= 1'b1;
                  rd_addr   <= RGB_BASE;
                  iss_phase <= '0;
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  address <= rd_addr;
                  // pointer parks on the last word instead of wrapping
                  if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 18'd1;
                  if (iss_phase == 2'd2) begin
                     iss_phase <= '0;
                     if (rd_addr == LAST_ADDR) state <= S_DRAIN;
                  end else begin
                     iss_phase <= iss_phase + 2'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (!in_flight && (fifo_cnt == '0)) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               frame_done <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Phase tag pipeline: element SRAM_LAT-1 lines up with the returning word
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         pipe_vld <= '0;
         for (int unsigned i = 0; i < SRAM_LAT; i++) pipe_ph[i] <= '0;
      end else begin
         pipe_vld[0] <= issue;
         pipe_ph[0]  <= iss_phase;
         for (int unsigned i = 1; i < SRAM_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_ph[i]  <= pipe_ph[i-1];
         end
      end
   end

   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         r0_q <= '0;
         g0_q <= '0;
         r1_q <= '0;
      end else if (ret_vld) begin
         if (ret_ph == 2'd0) begin
            r0_q <= SRAM_read_data[15:8];
            g0_q <= SRAM_read_data[7:0];
         end else if (ret_ph == 2'd1) begin
            r1_q <= SRAM_read_data[7:0];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Pixel FIFO and credit accounting
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         wr_idx   <= '0;
         rd_idx   <= '0;
         fifo_cnt <= '0;
         resv_cnt <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         resv_cnt <= resv_next;
         if (push) begin
            fifo_mem[wr_idx] <= push_data;
            wr_idx           <= wr_idx + AW'(1);
         end
         if (pop) rd_idx <= rd_idx + AW'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
         else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Raster coordinates of the head pixel
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
      if (!Resetn) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (pop) begin
         if (x_cnt == 9'(IMG_W - 1)) begin
            x_cnt <= '0;
            if (y_cnt == 8'(IMG_H - 1)) y_cnt <= '0;
            else                        y_cnt <= y_cnt + 8'd1;
         end else begin
            x_cnt <= x_cnt + 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_rgb_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_rgb_frame_streamer
//   Bench for rgb_frame_streamer using a reduced 20x8 frame placed so that the
//   last word lands on address 18'h3FFFF. A 3-edge SRAM model feeds the DUT; a
//   scoreboard derives every expected pixel and coordinate from the memory
//   layout and the pop index.
// -----------------------------------------------------------------------------
module tb_rgb_frame_streamer;
   localparam int          W      = 20;
   localparam int          H      = 8;
   localparam int          NPIX   = W * H;
   localparam int          NWORDS = NPIX * 3 / 2;
   localparam int          DEPTH  = 8;
   localparam logic [17:0] BASE   = 18'(262144 - NWORDS);
   localparam int          BUDGET = 5000;

   logic        CLOCK_50_I = 1'b0;
   logic        Resetn     = 1'b0;
   logic        start_bit  = 1'b0;
   logic [15:0] SRAM_read_data;
   logic [17:0] address;
   logic        write_en_n, busy, frame_done;

   rgb_frame_streamer_if pix();

   rgb_frame_streamer #(
      .RGB_BASE(BASE), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH), .SRAM_LAT(3)
   ) dut (
      .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .start_bit(start_bit),
      .SRAM_read_data(SRAM_read_data), .address(address),
      .write_en_n(write_en_n), .busy(busy), .frame_done(frame_done),
      .pix(pix)
   );

   always #10 CLOCK_50_I = ~CLOCK_50_I;

   // SRAM model: data for the address registered at edge t is stable before t+3
   logic [15:0] mem [NWORDS];
   logic [15:0] rd1, rd2;
   always @(posedge CLOCK_50_I) begin
      rd1 <= (address >= BASE) ? mem[int'(address - BASE)] : 16'hBAD0;
      rd2 <= rd1;
   end
   assign SRAM_read_data = rd2;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input int n);
      int k;
      logic [15:0] w0, w1, w2;
      k  = n / 2;
      w0 = mem[3*k];
      w1 = mem[3*k+1];
      w2 = mem[3*k+2];
      return (n % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
   endfunction

   // ready driver: 0 hold low, 1 always, 2 random 50%, 3 random 25%
   int ready_mode = 1;
   initial begin
      pix.pixel_ready = 1'b0;
      forever begin
         @(posedge CLOCK_50_I);
         #1;
         case (ready_mode)
            0:       pix.pixel_ready = 1'b0;
            1:       pix.pixel_ready = 1'b1;
            2:       pix.pixel_ready = 1'($urandom_range(0, 1));
            default: pix.pixel_ready = ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   // scoreboard and bus monitors
   int          pop_idx = 0;
   int          n_reads = 0;
   int          fd_count = 0;
   logic [17:0] exp_addr = BASE;
   logic [17:0] last_addr = '0;
   logic        prev_busy = 1'b0;

   initial forever begin
      @(negedge CLOCK_50_I);
      if (!Resetn) begin
         last_addr = '0;
         prev_busy = 1'b0;
      end else begin
         if (pix.pixel_valid && pix.pixel_ready) begin
            if (pop_idx >= NPIX) begin
               check("extra_pop", 64'(pop_idx), 64'(NPIX - 1));
            end else begin
               check("pix_rgb", {pix.pixel_R, pix.pixel_G, pix.pixel_B}, exp_rgb(pop_idx));
               check("pix_xy", {pix.pixel_x, pix.pixel_y}, {9'(pop_idx % W), 8'(pop_idx / W)});
            end
            pop_idx++;
         end
         if (address != last_addr) begin
            check("addr_seq", address, exp_addr);
            exp_addr  = exp_addr + 18'd1;
            n_reads++;
            last_addr = address;
         end
         if (frame_done) begin
            fd_count++;
            check("done_busy_fall", {prev_busy, busy}, 2'b10);
         end
         prev_busy = busy;
      end
   end

   // a push into a full FIFO would silently lose a pixel
   initial forever begin
      @(negedge CLOCK_50_I);
      assert (!(Resetn && dut.push && (int'(dut.fifo_cnt) == DEPTH))) else begin
         errors++;
         $display("FAIL fifo_overflow push with occupancy=%0d required<%0d", dut.fifo_cnt, DEPTH);
      end
   end

   task automatic tick();
      @(posedge CLOCK_50_I);
      #1;
   endtask

   int fd0;

   task automatic prep_frame(input bit unpack_words);
      for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
      if (unpack_words) begin
         mem[0] = 16'h1122;
         mem[1] = 16'h3344;
         mem[2] = 16'h5566;
      end
      pop_idx  = 0;
      n_reads  = 0;
      exp_addr = BASE;
      fd0      = fd_count;
   endtask

   task automatic pulse_start();
      start_bit = 1'b1;
      tick();
      start_bit = 1'b0;
   endtask

   task automatic frame_end_checks(input string tag);
      int c;
      c = 0;
      while (fd_count == fd0 && c < BUDGET) begin
         @(negedge CLOCK_50_I);
         c++;
      end
      check({tag, "_done_seen"}, 64'(fd_count != fd0), 64'd1);
      repeat (6) tick();
      @(negedge CLOCK_50_I);
      check({tag, "_done_count"}, 64'(fd_count - fd0), 64'd1);
      check({tag, "_pops"}, 64'(pop_idx), 64'(NPIX));
      check({tag, "_reads"}, 64'(n_reads), 64'(NWORDS));
      check({tag, "_last_addr"}, address, 18'h3FFFF);
      check({tag, "_xy_home"}, {pix.pixel_x, pix.pixel_y}, 17'd0);
      check({tag, "_idle"}, {busy, pix.pixel_valid}, 2'b00);
      tick();
   endtask

   task automatic reset_values(input string tag);
      check({tag, "_addr"}, address, 18'd0);
      check({tag, "_wen"}, write_en_n, 1'b1);
      check({tag, "_valid"}, pix.pixel_valid, 1'b0);
      check({tag, "_rgb"}, {pix.pixel_R, pix.pixel_G, pix.pixel_B}, 24'd0);
      check({tag, "_xy"}, {pix.pixel_x, pix.pixel_y}, 17'd0);
      check({tag, "_busy_done"}, {busy, frame_done}, 2'b00);
   endtask

   typedef struct {
      int mode;        // ready_mode during the frame
      int restart_at;  // pop index for a stray start_bit, -1 for none
   } scen_t;
   scen_t scen [4];

   initial begin
      int c;
      scen[0] = '{mode: 1, restart_at: -1};
      scen[1] = '{mode: 2, restart_at: -1};
      scen[2] = '{mode: 2, restart_at: 30};
      scen[3] = '{mode: 3, restart_at: 100};

      // reset state
      repeat (3) @(negedge CLOCK_50_I);
      reset_values("rst");
      tick();
      Resetn = 1'b1;
      tick();

      // full-rate frame: first-address timing, first-pixel latency, unpack
      ready_mode = 1;
      prep_frame(1'b1);
      tick();
      pulse_start();                           // edge 0 taken
      @(negedge CLOCK_50_I);
      check("start_busy", busy, 1'b1);
      check("addr_before_e1", address, 18'd0);
      tick();                                  // edge 1
      @(negedge CLOCK_50_I);
      check("addr_after_e1", address, BASE);
      tick(); tick(); tick();                  // edges 2..4
      @(negedge CLOCK_50_I);
      check("valid_after_e4", pix.pixel_valid, 1'b0);
      tick();                                  // edge 5
      @(negedge CLOCK_50_I);
      check("valid_after_e5", pix.pixel_valid, 1'b1);
      check("pix0_rgb", {pix.pixel_R, pix.pixel_G, pix.pixel_B}, 24'h112233);
      tick();                                  // edge 6
      @(negedge CLOCK_50_I);
      check("pix1_rgb", {pix.pixel_R, pix.pixel_G, pix.pixel_B}, 24'h445566);
      check("pix1_xy", {pix.pixel_x, pix.pixel_y}, {9'd1, 8'd0});
      frame_end_checks("full");

      // backpressure: reads stop once four groups fill the FIFO
      ready_mode = 0;
      prep_frame(1'b0);
      pulse_start();
      repeat (60) tick();
      @(negedge CLOCK_50_I);
      check("bp_reads", 64'(n_reads), 64'd12);
      check("bp_last_addr", address, BASE + 18'd11);
      check("bp_occupancy", 64'(dut.fifo_cnt), 64'(DEPTH));
      check("bp_valid", pix.pixel_valid, 1'b1);
      check("bp_no_pop", 64'(pop_idx), 64'd0);
      ready_mode = 1;
      frame_end_checks("bp");

      // table-driven frames under random backpressure and stray start pulses
      for (int i = 0; i < 4; i++) begin
         ready_mode = scen[i].mode;
         prep_frame(1'b0);
         pulse_start();
         if (scen[i].restart_at >= 0) begin
            c = 0;
            while (pop_idx < scen[i].restart_at && c < BUDGET) begin
               @(negedge CLOCK_50_I);
               c++;
            end
            check("restart_reached", 64'(pop_idx >= scen[i].restart_at), 64'd1);
            tick();
            pulse_start();
         end
         frame_end_checks($sformatf("scen%0d", i));
      end

      // mid-frame reset aborts the frame; no late push afterwards
      ready_mode = 2;
      prep_frame(1'b0);
      pulse_start();
      c = 0;
      while (pop_idx < 50 && c < BUDGET) begin
         @(negedge CLOCK_50_I);
         c++;
      end
      check("mid_reached", 64'(pop_idx >= 50), 64'd1);
      tick();
      Resetn = 1'b0;
      tick();
      @(negedge CLOCK_50_I);
      reset_values("mid_rst");
      tick();
      Resetn = 1'b1;
      repeat (8) tick();
      @(negedge CLOCK_50_I);
      check("post_rst_valid", pix.pixel_valid, 1'b0);
      check("post_rst_addr", address, 18'd0);
      check("post_rst_busy", busy, 1'b0);
      tick();
      ready_mode = 1;
      prep_frame(1'b0);
      pulse_start();
      frame_end_checks("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
